// File: rtl/regfile_pkg.sv
// Shared widths, register-file constants and sequencer state encoding
// for the register-file port arbiter.
package regfile_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned XZR_IDX    = 31;
    localparam int unsigned NUM_CLEAR  = 31;

    typedef enum logic {
        INIT,
        SERVE
    } state_t;

endpackage

// File: rtl/regfile_port_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; on contention the requester that
// was not granted most recently wins.
module rr_arbiter2 (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);

    logic lastGrant;

    always_comb begin
        grant = '0;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = lastGrant ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

    // Reset value 1 lets client 0 win the first contended cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lastGrant <= 1'b1;
        end else if (grant[0]) begin
            lastGrant <= 1'b0;
        end else if (grant[1]) begin
            lastGrant <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one 2R/1W register file between two clients: clears X0..X30
// after reset, then grants one request per cycle with registered responses.
module regfile_port_arbiter #(
    parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  req_valid0,
    input  logic                  req_valid1,
    output logic                  req_ready0,
    output logic                  req_ready1,
    input  logic [ADDR_WIDTH-1:0] req_ra0,
    input  logic [ADDR_WIDTH-1:0] req_ra1,
    input  logic [ADDR_WIDTH-1:0] req_rb0,
    input  logic [ADDR_WIDTH-1:0] req_rb1,
    input  logic [ADDR_WIDTH-1:0] req_rw0,
    input  logic [ADDR_WIDTH-1:0] req_rw1,
    input  logic                  req_we0,
    input  logic                  req_we1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic                  rsp_valid0,
    output logic                  rsp_valid1,
    output logic [DATA_WIDTH-1:0] rsp_a0,
    output logic [DATA_WIDTH-1:0] rsp_a1,
    output logic [DATA_WIDTH-1:0] rsp_b0,
    output logic [DATA_WIDTH-1:0] rsp_b1,
    output logic [ADDR_WIDTH-1:0] RA,
    output logic [ADDR_WIDTH-1:0] RB,
    output logic [ADDR_WIDTH-1:0] RW,
    output logic [DATA_WIDTH-1:0] BusW,
    output logic                  RegWr,
    input  logic [DATA_WIDTH-1:0] BusA,
    input  logic [DATA_WIDTH-1:0] BusB,
    output logic                  init_done
);

    import regfile_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] XZR     = ADDR_WIDTH'(XZR_IDX);
    localparam logic [ADDR_WIDTH-1:0] LAST_CLR = ADDR_WIDTH'(NUM_CLEAR - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] clearCnt;
    logic [1:0]            grant;
    logic                  serving;

    // Reset is synchronous, so gate grants while it is held high.
    assign serving = (state == SERVE) && !Reset;

    rr_arbiter2 uArb (
        .Clk    (Clk),
        .Reset  (Reset),
        .req    ({req_valid1, req_valid0}),
        .enable (serving),
        .grant  (grant)
    );

    assign req_ready0 = grant[0];
    assign req_ready1 = grant[1];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= INIT;
            clearCnt  <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (clearCnt == LAST_CLR) begin
                        state     <= SERVE;
                        init_done <= 1'b1;
                    end else begin
                        clearCnt <= clearCnt + 1'b1;
                    end
                end
                SERVE: state <= SERVE;
                default: begin
                    state    <= INIT;
                    clearCnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        RA    = XZR;
        RB    = XZR;
        RW    = XZR;
        BusW  = '0;
        RegWr = 1'b0;
        if (state == INIT) begin
            RW    = clearCnt;
            RegWr = !Reset;
        end else if (grant[0]) begin
            RA    = req_ra0;
            RB    = req_rb0;
            RW    = req_rw0;
            BusW  = req_wdata0;
            RegWr = req_we0;
        end else if (grant[1]) begin
            RA    = req_ra1;
            RB    = req_rb1;
            RW    = req_rw1;
            BusW  = req_wdata1;
            RegWr = req_we1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            rsp_a0     <= '0;
            rsp_b0     <= '0;
            rsp_a1     <= '0;
            rsp_b1     <= '0;
        end else begin
            rsp_valid0 <= grant[0];
            rsp_valid1 <= grant[1];
            if (grant[0]) begin
                rsp_a0 <= BusA;
                rsp_b0 <= BusB;
            end
            if (grant[1]) begin
                rsp_a1 <= BusA;
                rsp_b1 <= BusB;
            end
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench: a register-file model (falling-edge write, combinational
// read, X31 reads 0) sits behind the arbiter; expected responses are queued per client.
module tb_regfile_port_arbiter;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
    logic        req_ready0, req_ready1;
    logic [4:0]  req_ra0 = '0, req_ra1 = '0, req_rb0 = '0, req_rb1 = '0;
    logic [4:0]  req_rw0 = '0, req_rw1 = '0;
    logic        req_we0 = 1'b0, req_we1 = 1'b0;
    logic [63:0] req_wdata0 = '0, req_wdata1 = '0;
    logic        rsp_valid0, rsp_valid1;
    logic [63:0] rsp_a0, rsp_a1, rsp_b0, rsp_b1;
    logic [4:0]  RA, RB, RW;
    logic [63:0] BusW, BusA, BusB;
    logic        RegWr, init_done;

    logic [63:0] regs [32];
    exp_t        q0 [$];
    exp_t        q1 [$];
    int          tests = 0;
    int          failed = 0;
    logic        prevT0 = 1'b0, prevT1 = 1'b0;

    regfile_port_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid0(req_valid0), .req_valid1(req_valid1),
        .req_ready0(req_ready0), .req_ready1(req_ready1),
        .req_ra0(req_ra0), .req_ra1(req_ra1),
        .req_rb0(req_rb0), .req_rb1(req_rb1),
        .req_rw0(req_rw0), .req_rw1(req_rw1),
        .req_we0(req_we0), .req_we1(req_we1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_a0(rsp_a0), .rsp_a1(rsp_a1), .rsp_b0(rsp_b0), .rsp_b1(rsp_b1),
        .RA(RA), .RB(RB), .RW(RW), .BusW(BusW), .RegWr(RegWr),
        .BusA(BusA), .BusB(BusB), .init_done(init_done)
    );

    always #5 Clk = ~Clk;

    // Register file model; stale non-zero contents make the clear observable.
    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 64'hDEAD_0000_0000_0000 | 64'(i + 1);
        forever begin
            @(negedge Clk);
            if (RegWr === 1'b1 && RW != 5'd31) regs[RW] = BusW;
        end
    end

    assign BusA = (RA == 5'd31) ? 64'd0 : regs[RA];
    assign BusB = (RB == 5'd31) ? 64'd0 : regs[RB];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected data on each response and checks one-cycle latency.
    always @(negedge Clk) begin
        exp_t e;
        if (rsp_valid0 === 1'b1) begin
            if (q0.size() == 0) begin
                tests++; failed++;
                $display("FAIL rsp0_unexpected: got rsp_valid0=1 expected no response at %0t", $time);
            end else begin
                e = q0.pop_front();
                check("rsp_a0", rsp_a0, e.a);
                check("rsp_b0", rsp_b0, e.b);
            end
        end
        if (rsp_valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                tests++; failed++;
                $display("FAIL rsp1_unexpected: got rsp_valid1=1 expected no response at %0t", $time);
            end else begin
                e = q1.pop_front();
                check("rsp_a1", rsp_a1, e.a);
                check("rsp_b1", rsp_b1, e.b);
            end
        end
        if (rsp_valid0 === 1'b1 || rsp_valid1 === 1'b1)
            check("rsp_exclusive", 64'(rsp_valid0 & rsp_valid1), 64'd0);
        check("rsp_valid0_latency", 64'(rsp_valid0), 64'(prevT0));
        check("rsp_valid1_latency", 64'(rsp_valid1), 64'(prevT1));
        prevT0 = req_valid0 && req_ready0 && !Reset;
        prevT1 = req_valid1 && req_ready1 && !Reset;
    end

    // Called one #1 after release; returns at the negedge of cycle 31.
    task automatic checkInit();
        for (int n = 0; n <= 31; n++) begin
            @(negedge Clk);
            if (n == 0) begin
                check("post_reset_rsp_valid", 64'({rsp_valid1, rsp_valid0}), 64'd0);
            end
            if (n < 31) begin
                check("init_done_low", 64'(init_done), 64'd0);
                check("init_RegWr", 64'(RegWr), 64'd1);
                check("init_RW", 64'(RW), 64'(n));
                check("init_BusW", BusW, 64'd0);
                check("init_RA_RB", 64'({RA, RB}), 64'({5'd31, 5'd31}));
                check("init_ready", 64'({req_ready1, req_ready0}), 64'd0);
            end else begin
                check("init_done_high", 64'(init_done), 64'd1);
            end
        end
    endtask

    task automatic issue(input int c, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] rw, input logic we, input logic [63:0] wd,
                         input logic [63:0] expA, input logic [63:0] expB);
        bit got = 0;
        if (c == 0) begin
            req_ra0 = ra; req_rb0 = rb; req_rw0 = rw; req_we0 = we; req_wdata0 = wd; req_valid0 = 1'b1;
        end else begin
            req_ra1 = ra; req_rb1 = rb; req_rw1 = rw; req_we1 = we; req_wdata1 = wd; req_valid1 = 1'b1;
        end
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge Clk);
            if (c == 0 && req_ready0) begin q0.push_back('{a: expA, b: expB}); got = 1; end
            if (c == 1 && req_ready1) begin q1.push_back('{a: expA, b: expB}); got = 1; end
        end
        if (!got) begin
            tests++; failed++;
            $display("FAIL grant_timeout: got no ready for client %0d expected grant within 50 cycles", c);
        end
        @(posedge Clk); #1;
        if (c == 0) req_valid0 = 1'b0; else req_valid1 = 1'b0;
        req_we0 = 1'b0; req_we1 = 1'b0;
    endtask

    // One cycle with both clients requesting: check the grant and queue the response.
    task automatic dualCycle(input logic g0, input logic g1, input exp_t e0, input exp_t e1);
        @(negedge Clk);
        check("dual_grant", 64'({req_ready1, req_ready0}), 64'({g1, g0}));
        if (req_ready0) q0.push_back(e0);
        if (req_ready1) q1.push_back(e1);
        @(posedge Clk); #1;
    endtask

    initial begin
        exp_t r0, r1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_ready", 64'({req_ready1, req_ready0}), 64'd0);
        check("reset_rsp_valid", 64'({rsp_valid1, rsp_valid0}), 64'd0);
        check("reset_rsp_data", rsp_a0 | rsp_b0 | rsp_a1 | rsp_b1, 64'd0);
        check("reset_init_done", 64'(init_done), 64'd0);
        check("reset_RegWr", 64'(RegWr), 64'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        // Clear sequence, then read back every register pair X0..X30.
        checkInit();
        @(posedge Clk); #1;
        for (int i = 0; i <= 30; i++)
            issue(0, 5'(i), 5'(30 - i), 5'd31, 1'b0, 64'd0, 64'd0, 64'd0);

        // Write X10 then read it back alongside XZR.
        issue(0, 5'd31, 5'd31, 5'd10, 1'b1, 64'h1010, 64'd0, 64'd0);
        issue(0, 5'd10, 5'd31, 5'd31, 1'b0, 64'd0, 64'h1010, 64'd0);

        // Contention: client 0 was granted last, so client 1 leads.
        req_ra0 = 5'd10; req_rb0 = 5'd31; req_rw0 = 5'd31; req_we0 = 1'b0;
        req_ra1 = 5'd31; req_rb1 = 5'd10; req_rw1 = 5'd31; req_we1 = 1'b0;
        req_valid0 = 1'b1; req_valid1 = 1'b1;
        r0 = '{a: 64'h1010, b: 64'd0};
        r1 = '{a: 64'd0, b: 64'h1010};
        for (int k = 0; k < 8; k++) dualCycle(k[0], !k[0], r0, r1);
        req_valid0 = 1'b0; req_valid1 = 1'b0;

        // Write-before-read on the same register.
        issue(1, 5'd10, 5'd13, 5'd13, 1'b1, 64'hABCD, 64'h1010, 64'hABCD);

        // XZR writes are discarded.
        issue(0, 5'd31, 5'd13, 5'd31, 1'b1, 64'h1234_5678, 64'd0, 64'hABCD);
        issue(0, 5'd31, 5'd13, 5'd31, 1'b0, 64'd0, 64'd0, 64'hABCD);

        // Reset in the cycle client 1 would be granted.
        req_ra0 = 5'd10; req_rb0 = 5'd13; req_rw0 = 5'd31; req_we0 = 1'b0;
        req_ra1 = 5'd13; req_rb1 = 5'd31; req_rw1 = 5'd31; req_we1 = 1'b0;
        req_valid0 = 1'b1; req_valid1 = 1'b1;
        r0 = '{a: 64'h1010, b: 64'hABCD};
        r1 = '{a: 64'hABCD, b: 64'd0};
        dualCycle(1'b0, 1'b1, r0, r1);
        dualCycle(1'b1, 1'b0, r0, r1);
        Reset = 1'b1;
        @(negedge Clk);
        check("midreset_ready", 64'({req_ready1, req_ready0}), 64'd0);
        check("midreset_RegWr", 64'(RegWr), 64'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        checkInit();
        r0 = '{a: 64'd0, b: 64'd0};
        r1 = '{a: 64'd0, b: 64'd0};
        check("post_init_first_grant", 64'({req_ready1, req_ready0}), 64'b01);
        if (req_ready0) q0.push_back(r0);
        if (req_ready1) q1.push_back(r1);
        @(posedge Clk); #1;
        dualCycle(1'b0, 1'b1, r0, r1);
        dualCycle(1'b1, 1'b0, r0, r1);
        req_valid0 = 1'b0; req_valid1 = 1'b0;

        repeat (3) @(posedge Clk);
        #1;
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $fatal(1, "watchdog");
    end

endmodule
